gpio_pad_bank: RTL and testbench

//   Parametrised GPIO pad controller between the SoC GPIO peripheral (read/write/writeEnable)
//   and the FPGA tristate pad primitives (O/I/T, T high = input).

---
 rtl/gpio_pad_pkg.sv | 13 +
 rtl/gpio_pad_filter.sv | 80 ++++++++
 rtl/gpio_pad_bank.sv | 76 +++++++
 tb/tb_gpio_pad_bank.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pad_pkg.sv
// Purpose: shared defaults and constants for the GPIO pad bank and its channel filter.
// Latency: n/a (constants only).
// Backpressure: n/a.
package gpio_pad_pkg;

  localparam int DEF_CHANNELS     = 16;
  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_FILTER_WIDTH = 8;

  // A filter length of zero means the stable value follows the synchroniser every cycle.
  localparam int FILTER_BYPASS    = 0;

endpackage

// File: rtl/gpio_pad_filter.sv
// Purpose: one GPIO input channel: synchroniser, glitch filter, stable register, edge-pending bit.
// Latency: pad_in edge -> stable = SYNC_STAGES + filter_len + 1 cycles; pending one cycle later.
// Backpressure: none; free-running per clock.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   pad_in          raw pad input (asynchronous to clk)
//   filter_len      stable cycles required before accepting a change
//   irq_rise_en     set pending on filtered rising edge
//   irq_fall_en     set pending on filtered falling edge
//   irq_clear       clears pending (a coincident new edge wins)
//   stable          filtered, synchronised pad value
//   pending         sticky edge-pending bit
module gpio_pad_filter
  import gpio_pad_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int FILTER_WIDTH = DEF_FILTER_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pad_in,
  input  logic [FILTER_WIDTH-1:0] filter_len,
  input  logic                    irq_rise_en,
  input  logic                    irq_fall_en,
  input  logic                    irq_clear,
  output logic                    stable,
  output logic                    pending
);

  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    sync;
  logic [FILTER_WIDTH-1:0] cnt_q;
  logic [FILTER_WIDTH-1:0] cnt_d;
  logic                    stable_d;
  logic                    prev_q;
  logic                    accept;
  logic                    rise;
  logic                    fall;

  assign sync = sync_q[SYNC_STAGES-1];

  // ">=" rather than "==" so that shrinking filter_len below a count already in
  // progress accepts on the next edge instead of counting on and wrapping.
  assign accept = (filter_len == FILTER_WIDTH'(FILTER_BYPASS)) || (cnt_q >= filter_len);

  always_comb begin
    cnt_d    = '0;
    stable_d = stable;
    if (sync != stable) begin
      if (accept) begin
        stable_d = sync;
        cnt_d    = '0;
      end else begin
        cnt_d    = cnt_q + 1'b1;
      end
    end
  end

  // prev_q resets to the same value as stable, so reset release never looks like an edge.
  assign rise = ~prev_q &  stable;
  assign fall =  prev_q & ~stable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      stable  <= 1'b0;
      prev_q  <= 1'b0;
      pending <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pad_in};
      cnt_q   <= cnt_d;
      stable  <= stable_d;
      prev_q  <= stable;
      pending <= (pending & ~irq_clear) | (rise & irq_rise_en) | (fall & irq_fall_en);
    end
  end

endmodule

// File: rtl/gpio_pad_bank.sv
// Purpose: GPIO bank between peripheral pins and tristate pads; open-drain, glitch filter, edge IRQs.
// Latency: output path 1 cycle; input path SYNC_STAGES + cfg_filterLen + 1; irq 2 cycles after pins_read.
// Backpressure: none; all paths free-running.
//
// Ports:
//   io_clock, io_reset_n          clock, asynchronous active-low reset
//   pins_write/pins_writeEnable   peripheral output value / drive enable per channel
//   pins_read                     synchronised, filtered pad value (also visible while driving)
//   cfg_openDrain                 per-channel open-drain (drive low only)
//   cfg_filterLen                 glitch-filter length shared by all channels (0 = bypass)
//   cfg_irqRise/cfg_irqFall       per-channel edge enables for irq_pending
//   irq_clear, irq_pending, irq   pending clear pulse, sticky pending bits, registered OR
//   pad_i, pad_o, pad_t           pad buffer connections (pad_t high = high-Z)
module gpio_pad_bank
  import gpio_pad_pkg::*;
#(
  parameter int CHANNELS     = DEF_CHANNELS,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int FILTER_WIDTH = DEF_FILTER_WIDTH
) (
  input  logic                    io_clock,
  input  logic                    io_reset_n,
  input  logic [CHANNELS-1:0]     pins_write,
  input  logic [CHANNELS-1:0]     pins_writeEnable,
  output logic [CHANNELS-1:0]     pins_read,
  input  logic [CHANNELS-1:0]     cfg_openDrain,
  input  logic [FILTER_WIDTH-1:0] cfg_filterLen,
  input  logic [CHANNELS-1:0]     cfg_irqRise,
  input  logic [CHANNELS-1:0]     cfg_irqFall,
  input  logic [CHANNELS-1:0]     irq_clear,
  output logic [CHANNELS-1:0]     irq_pending,
  output logic                    irq,
  input  logic [CHANNELS-1:0]     pad_i,
  output logic [CHANNELS-1:0]     pad_o,
  output logic [CHANNELS-1:0]     pad_t
);

  logic [CHANNELS-1:0] pad_o_d;
  logic [CHANNELS-1:0] pad_t_d;

  // Open-drain channels never drive high: the pad is released (high-Z) for a 1
  // and driven to 0 only when enabled with a 0.
  assign pad_o_d = pins_write & ~cfg_openDrain;
  assign pad_t_d = (~pins_writeEnable & ~cfg_openDrain)
                 | (~(pins_writeEnable & ~pins_write) & cfg_openDrain);

  always_ff @(posedge io_clock or negedge io_reset_n) begin
    if (!io_reset_n) begin
      pad_o <= '0;
      pad_t <= '1;
      irq   <= 1'b0;
    end else begin
      pad_o <= pad_o_d;
      pad_t <= pad_t_d;
      irq   <= |irq_pending;
    end
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
    gpio_pad_filter #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_WIDTH (FILTER_WIDTH)
    ) u_filter (
      .clk         (io_clock),
      .rst_n       (io_reset_n),
      .pad_in      (pad_i[ch]),
      .filter_len  (cfg_filterLen),
      .irq_rise_en (cfg_irqRise[ch]),
      .irq_fall_en (cfg_irqFall[ch]),
      .irq_clear   (irq_clear[ch]),
      .stable      (pins_read[ch]),
      .pending     (irq_pending[ch])
    );
  end

endmodule

// File: tb/tb_gpio_pad_bank.sv
// Purpose: directed self-checking bench for gpio_pad_bank (16 channels, 2 sync stages, 8-bit filter).
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled at the same point.
// Backpressure: n/a.
module tb_gpio_pad_bank;

  logic        io_clock = 1'b0;
  logic        io_reset_n;
  logic [15:0] pins_write;
  logic [15:0] pins_writeEnable;
  logic [15:0] pins_read;
  logic [15:0] cfg_openDrain;
  logic [7:0]  cfg_filterLen;
  logic [15:0] cfg_irqRise;
  logic [15:0] cfg_irqFall;
  logic [15:0] irq_clear;
  logic [15:0] irq_pending;
  logic        irq;
  logic [15:0] pad_i;
  logic [15:0] pad_o;
  logic [15:0] pad_t;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 io_clock = ~io_clock;

  gpio_pad_bank #(
    .CHANNELS     (16),
    .SYNC_STAGES  (2),
    .FILTER_WIDTH (8)
  ) dut (
    .io_clock         (io_clock),
    .io_reset_n       (io_reset_n),
    .pins_write       (pins_write),
    .pins_writeEnable (pins_writeEnable),
    .pins_read        (pins_read),
    .cfg_openDrain    (cfg_openDrain),
    .cfg_filterLen    (cfg_filterLen),
    .cfg_irqRise      (cfg_irqRise),
    .cfg_irqFall      (cfg_irqFall),
    .irq_clear        (irq_clear),
    .irq_pending      (irq_pending),
    .irq              (irq),
    .pad_i            (pad_i),
    .pad_o            (pad_o),
    .pad_t            (pad_t)
  );

  typedef struct {
    string       name;
    logic [15:0] we;
    logic [15:0] wr;
    logic [15:0] od;
    logic [15:0] exp_o;
    logic [15:0] exp_t;
  } out_vec_t;

  out_vec_t vecs [6];

  task automatic tick();
    @(posedge io_clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    // {name, writeEnable, write, openDrain, expected pad_o, expected pad_t}
    vecs[0] = '{"pp_ch0_drive_high", 16'h0001, 16'h0001, 16'h0000, 16'h0001, 16'hfffe};
    vecs[1] = '{"pp_all_released",   16'h0000, 16'hffff, 16'h0000, 16'hffff, 16'hffff};
    vecs[2] = '{"od_ch3_write1",     16'h0008, 16'h0008, 16'h0008, 16'h0000, 16'hffff};
    vecs[3] = '{"od_ch3_write0",     16'h0008, 16'h0000, 16'h0008, 16'h0000, 16'hfff7};
    vecs[4] = '{"mixed_pp_od",       16'hff00, 16'ha5a5, 16'h0f0f, 16'ha0a0, 16'h05ff};
    vecs[5] = '{"od_all_pattern",    16'hffff, 16'h1234, 16'hffff, 16'h0000, 16'h1234};

    io_reset_n       = 1'b0;
    pins_write       = '0;
    pins_writeEnable = '0;
    cfg_openDrain    = '0;
    cfg_filterLen    = 8'd0;
    cfg_irqRise      = '0;
    cfg_irqFall      = '0;
    irq_clear        = '0;
    pad_i            = 16'hffff;

    // Reset holds everything idle even with all pads high and inputs toggling.
    pins_writeEnable = 16'hffff;
    ticks(4);
    check("reset_pad_t",     pad_t,       16'hffff);
    check("reset_pad_o",     pad_o,       16'h0000);
    check("reset_pins_read", pins_read,   16'h0000);
    check("reset_pending",   irq_pending, 16'h0000);
    check("reset_irq",       irq,         1'b0);
    pins_writeEnable = '0;
    pad_i = '0;
    io_reset_n = 1'b1;
    ticks(3);

    // Output path vectors: value appears one edge after being applied.
    for (int i = 0; i < 6; i++) begin
      pins_writeEnable = vecs[i].we;
      pins_write       = vecs[i].wr;
      cfg_openDrain    = vecs[i].od;
      tick();
      check({vecs[i].name, "_pad_o"}, pad_o, vecs[i].exp_o);
      check({vecs[i].name, "_pad_t"}, pad_t, vecs[i].exp_t);
    end
    pins_writeEnable = '0;
    pins_write       = '0;
    cfg_openDrain    = '0;

    // Filter len 4: a 3-cycle pulse is rejected.
    cfg_filterLen = 8'd4;
    ticks(2);
    pad_i[2] = 1'b1;
    ticks(3);
    pad_i[2] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("filt_short_pulse", pins_read[2], 1'b0);
    end
    // Held level is accepted exactly 2+4+1 = 7 cycles after the edge.
    pad_i[2] = 1'b1;
    ticks(6);
    check("filt_len4_at6", pins_read[2], 1'b0);
    tick();
    check("filt_len4_at7", pins_read[2], 1'b1);
    ticks(3);
    check("filt_len4_held", pins_read, 16'h0004);

    // IRQ on rising edge of ch5, bypass filter.
    cfg_filterLen = 8'd0;
    tick();
    cfg_irqRise = 16'h0020;
    pad_i[5] = 1'b1;
    ticks(3);
    check("irq_bypass_read_at3", pins_read[5], 1'b1);
    check("irq_pend_not_yet",    irq_pending[5], 1'b0);
    tick();
    check("irq_pend_set",        irq_pending, 16'h0020);
    check("irq_not_yet",         irq, 1'b0);
    tick();
    check("irq_set",             irq, 1'b1);
    irq_clear = 16'h0020;
    tick();
    irq_clear = '0;
    check("irq_clear_alone",     irq_pending[5], 1'b0);
    tick();
    check("irq_drop",            irq, 1'b0);
    pad_i[5] = 1'b0;
    ticks(5);
    check("irq_fall_not_enabled", irq_pending[5], 1'b0);
    pad_i[5] = 1'b1;
    ticks(3);
    irq_clear = 16'h0020;       // coincident with the rise being registered
    tick();
    irq_clear = '0;
    check("irq_set_beats_clear", irq_pending[5], 1'b1);

    // Bypass toggle on ch7 with only falling-edge IRQ enabled.
    cfg_irqRise = '0;
    irq_clear = 16'hffff;
    tick();
    irq_clear = '0;
    ticks(2);
    check("irq_all_cleared", irq, 1'b0);
    cfg_irqFall = 16'h0080;
    for (int i = 0; i < 3; i++) begin
      pad_i[7] = 1'b1;
      ticks(4);
      check("bypass_rise_no_pend", irq_pending[7], 1'b0);
      pad_i[7] = 1'b0;
      ticks(4);
      check("bypass_fall_pend", irq_pending[7], 1'b1);
      irq_clear[7] = 1'b1;
      tick();
      irq_clear[7] = 1'b0;
      check("bypass_fall_cleared", irq_pending[7], 1'b0);
    end

    // Reset in the middle of a filter count, then release with the pad still high.
    cfg_irqFall = '0;
    cfg_filterLen = 8'd4;
    pad_i = 16'h0000;
    ticks(6);
    pad_i[9] = 1'b1;
    ticks(4);
    io_reset_n = 1'b0;
    #1;
    check("midrst_pins_read", pins_read, 16'h0000);
    check("midrst_pad_t",     pad_t,     16'hffff);
    check("midrst_pending",   irq_pending, 16'h0000);
    ticks(2);
    io_reset_n = 1'b1;
    ticks(6);
    check("midrst_refilter_at6", pins_read[9], 1'b0);
    tick();
    check("midrst_refilter_at7", pins_read[9], 1'b1);
    ticks(2);
    check("midrst_no_spurious", irq_pending, 16'h0000);
    check("midrst_no_irq",      irq, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
